// File: rtl/mem_if_pkg.sv
// mem_if_pkg
//   Types and constants shared by the data-port responder and the core-side
//   initiator: the responder FSM state encoding, word/byte-enable sizes, the
//   request bundle captured at accept time, and a byte-merge helper used for
//   byte-enabled stores.
package mem_if_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BE_W       = 4;
    localparam int DATA_W     = 8 * WORD_BYTES;
    localparam int ADDR_W     = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_req_t;

    // Replaces only the byte lanes whose enable bit is set.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] oldWord,
        input logic [DATA_W-1:0] newWord,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] result;
        result = oldWord;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) begin
                result[8*b +: 8] = newWord[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
//   Request/response handshake bundle between the core's MEM stage (master)
//   and the data memory responder (slave).
//   Request : req_valid/req_ready, req_we, req_addr, req_wdata, req_be
//   Response: rsp_valid/rsp_ready, rsp_rdata, rsp_err
interface data_mem_responder_if;
    import mem_if_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/sram_1rw.sv
// sram_1rw
//   Single-port synchronous word array with byte-enabled writes. When en_i is
//   high the addressed word is read into a register on the same edge (old
//   contents on a write). Contents are never reset.
//   Ports: clk_i, en_i, we_i, idx_i (word index), wdata_i, be_i, rdata_o
module sram_1rw
    import mem_if_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk_i,
    input  logic                           en_i,
    input  logic                           we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
    input  logic [DATA_W-1:0]              wdata_i,
    input  logic [BE_W-1:0]                be_i,
    output logic [DATA_W-1:0]              rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[idx_i] <= merge_bytes(mem_q[idx_i], wdata_i, be_i);
            end
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the core's data port. Accepts one load/store at
//   a time, waits WAIT_CYCLES extra cycles, performs the access on sram_1rw and
//   presents the response until the requester takes it.
//   Ports: clk, rst (async, active-low), bus (data_mem_responder_if.slave)
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    data_mem_responder_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_e            state_q;
    logic [3:0]        waitCnt_q;
    mem_req_t          req_q;
    logic              rspValid_q;
    logic              rspErr_q;
    logic              rspLoad_q;
    logic              addrErr;
    logic              accessNow;
    logic [DATA_W-1:0] sramRdata;

    // Misaligned, or any address bit above the array's byte range set.
    assign addrErr   = (req_q.addr[1:0] != 2'b00) || (req_q.addr[ADDR_W-1:IDX_W+2] != '0);
    assign accessNow = (state_q == WAIT) && (waitCnt_q == 4'd0);

    sram_1rw #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_sram (
        .clk_i  (clk),
        .en_i   (accessNow && !addrErr),
        .we_i   (req_q.we),
        .idx_i  (req_q.addr[2 +: IDX_W]),
        .wdata_i(req_q.wdata),
        .be_i   (req_q.be),
        .rdata_o(sramRdata)
    );

    // Request capture, wait countdown, access and response hold in one FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            waitCnt_q  <= 4'd0;
            req_q      <= '0;
            rspValid_q <= 1'b0;
            rspErr_q   <= 1'b0;
            rspLoad_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_q     <= '{we: bus.req_we, addr: bus.req_addr,
                                       wdata: bus.req_wdata, be: bus.req_be};
                        waitCnt_q <= 4'(WAIT_CYCLES);
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (waitCnt_q != 4'd0) begin
                        waitCnt_q <= waitCnt_q - 4'd1;
                    end else begin
                        state_q    <= RESP;
                        rspValid_q <= 1'b1;
                        rspErr_q   <= addrErr;
                        rspLoad_q  <= !req_q.we && !addrErr;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q    <= IDLE;
                        rspValid_q <= 1'b0;
                        rspErr_q   <= 1'b0;
                        rspLoad_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The SRAM read register is only loaded at the access edge, so gating it
    // with rspLoad_q keeps load data stable through RESP and zero otherwise.
    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rspValid_q;
    assign bus.rsp_err   = rspErr_q;
    assign bus.rsp_rdata = rspLoad_q ? sramRdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Three responder instances (WAIT_CYCLES 2, 4 and 0) sharing clock and
//   reset, driven through a virtual interface and checked against a
//   word-addressed reference memory held in an associative array.
module tb_data_mem_responder;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   curSel;
    int   curW;
    logic [31:0] refMem [int];
    virtual data_mem_responder_if vif;

    data_mem_responder_if if2 ();
    data_mem_responder_if if4 ();
    data_mem_responder_if if0 ();

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic select_dut(input int sel);
        curSel = sel;
        case (sel)
            0:       begin vif = if2; curW = 2; end
            1:       begin vif = if4; curW = 4; end
            default: begin vif = if0; curW = 0; end
        endcase
    endtask

    task automatic idle_all();
        for (int s = 0; s < 3; s++) begin
            select_dut(s);
            vif.req_valid = 1'b0; vif.req_we = 1'b0; vif.req_addr = '0;
            vif.req_wdata = '0;   vif.req_be = '0;   vif.rsp_ready = 1'b0;
        end
    endtask

    // Randomizes request pins while the responder is busy; it must ignore them.
    task automatic scramble();
        vif.req_valid = 1'($urandom); vif.req_we = 1'($urandom);
        vif.req_addr = $urandom; vif.req_wdata = $urandom; vif.req_be = 4'($urandom);
    endtask

    // Reference behaviour: a word array of 1024 entries addressed by byte
    // address / 4; unknown words are simply absent from refMem.
    function automatic void model_access(input int sel, input logic we, input logic [31:0] addr,
                                         input logic [31:0] wdata, input logic [3:0] be,
                                         output logic [31:0] expRd, output logic expErr,
                                         output logic known);
        int key;
        logic [31:0] w;
        expErr = (addr % 4 != 0) || (addr >= 32'd4096);
        expRd  = 32'h0;
        known  = 1'b1;
        if (expErr) return;
        key = sel * 65536 + int'(addr / 4);
        if (we) begin
            if (refMem.exists(key)) w = refMem[key];
            else if (be == 4'hF)    w = 32'h0;
            else return;
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
            refMem[key] = w;
        end else begin
            if (refMem.exists(key)) expRd = refMem[key];
            else known = 1'b0;
        end
    endfunction

    // One full transaction. lat = edges from accept to rsp_valid, -1 on timeout.
    task automatic drive_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input int hold,
                             output logic [31:0] rd, output logic er, output int lat,
                             output logic postValid, output logic postReady);
        int k;
        lat = -1; rd = '0; er = 1'b0; postValid = 1'b1; postReady = 1'b0;
        vif.rsp_ready = 1'b0;
        k = 0;
        @(negedge clk);
        while (!vif.req_ready && k < 50) begin @(negedge clk); k++; end
        vif.req_valid = 1'b1; vif.req_we = we; vif.req_addr = addr;
        vif.req_wdata = wdata; vif.req_be = be;
        @(negedge clk);
        scramble();
        k = 0;
        while (!vif.rsp_valid && k < 50) begin @(negedge clk); scramble(); k++; end
        if (!vif.rsp_valid) begin vif.req_valid = 1'b0; return; end
        lat = k; rd = vif.rsp_rdata; er = vif.rsp_err;
        repeat (hold) begin @(negedge clk); scramble(); end
        vif.rsp_ready = 1'b1;
        @(negedge clk);
        vif.req_valid = 1'b0;
        postValid = vif.rsp_valid; postReady = vif.req_ready;
        vif.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            select_dut(s);
            checks++;
            if (vif.req_ready !== 1'b1 || vif.rsp_valid !== 1'b0 || vif.rsp_rdata !== 32'h0 || vif.rsp_err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_outputs dut%0d: got ready=%b valid=%b rdata=%h err=%b, expected 1 0 0 0",
                         s, vif.req_ready, vif.rsp_valid, vif.rsp_rdata, vif.rsp_err);
            end
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            select_dut(s);
            checks++;
            if (vif.req_ready !== 1'b1 || vif.rsp_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL post_reset_idle dut%0d: got ready=%b valid=%b, expected 1 0", s, vif.req_ready, vif.rsp_valid);
            end
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd, expRd; logic er, pv, pr, expErr, known; int lat;
        select_dut(0);
        drive_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, pv, pr);
        model_access(curSel, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, expRd, expErr, known);
        checks++;
        if (er !== expErr || rd !== expRd) begin
            errors++; $display("[TB] FAIL store_rsp: got err=%b rdata=%h, expected err=%b rdata=%h", er, rd, expErr, expRd);
        end
        checks++;
        if (lat !== 3) begin errors++; $display("[TB] FAIL store_latency: got %0d, expected 3", lat); end
        checks++;
        if (pv !== 1'b0 || pr !== 1'b1) begin
            errors++; $display("[TB] FAIL store_release: got valid=%b ready=%b, expected 0 1", pv, pr);
        end
        drive_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, pv, pr);
        checks++;
        if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            errors++; $display("[TB] FAIL load_after_store: got err=%b rdata=%h, expected 0 deadbeef", er, rd);
        end
        checks++;
        if (lat !== 3) begin errors++; $display("[TB] FAIL load_latency: got %0d, expected 3", lat); end
    endtask

    task automatic test_byte_enables();
        logic [31:0] rd, expRd; logic er, pv, pr, expErr, known; int lat;
        select_dut(0);
        drive_txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat, pv, pr);
        model_access(curSel, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, expRd, expErr, known);
        drive_txn(1'b1, 32'h20, 32'h00000000, 4'h5, 1, rd, er, lat, pv, pr);
        model_access(curSel, 1'b1, 32'h20, 32'h00000000, 4'h5, expRd, expErr, known);
        drive_txn(1'b0, 32'h20, 32'h0, 4'hA, 0, rd, er, lat, pv, pr);
        checks++;
        if (er !== 1'b0 || rd !== 32'hFF00FF00) begin
            errors++; $display("[TB] FAIL byte_enable_merge: got err=%b rdata=%h, expected 0 ff00ff00", er, rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, expRd; logic er, pv, pr, expErr, known; int lat;
        select_dut(0);
        drive_txn(1'b1, 32'h0, 32'hA5A50001, 4'hF, 0, rd, er, lat, pv, pr);
        model_access(curSel, 1'b1, 32'h0, 32'hA5A50001, 4'hF, expRd, expErr, known);
        drive_txn(1'b0, 32'h22, 32'h0, 4'h0, 0, rd, er, lat, pv, pr);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("[TB] FAIL misaligned_load: got err=%b rdata=%h, expected 1 00000000", er, rd);
        end
        drive_txn(1'b1, 32'h1000, 32'h5555AAAA, 4'hF, 0, rd, er, lat, pv, pr);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("[TB] FAIL out_of_range_store: got err=%b rdata=%h, expected 1 00000000", er, rd);
        end
        drive_txn(1'b1, 32'h0, 32'hFFFFFFFF, 4'h0, 0, rd, er, lat, pv, pr);
        checks++;
        if (er !== 1'b0) begin errors++; $display("[TB] FAIL zero_be_store: got err=%b, expected 0", er); end
        drive_txn(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat, pv, pr);
        checks++;
        if (er !== 1'b0 || rd !== 32'hA5A50001) begin
            errors++; $display("[TB] FAIL word0_preserved: got err=%b rdata=%h, expected 0 a5a50001", er, rd);
        end
        drive_txn(1'b1, 32'hFFC, 32'h0BADF00D, 4'hF, 0, rd, er, lat, pv, pr);
        model_access(curSel, 1'b1, 32'hFFC, 32'h0BADF00D, 4'hF, expRd, expErr, known);
        drive_txn(1'b0, 32'hFFC, 32'h0, 4'h0, 0, rd, er, lat, pv, pr);
        checks++;
        if (er !== 1'b0 || rd !== 32'h0BADF00D) begin
            errors++; $display("[TB] FAIL last_word: got err=%b rdata=%h, expected 0 0badf00d", er, rd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] hd; logic he; int k;
        select_dut(0);
        vif.rsp_ready = 1'b0;
        @(negedge clk);
        vif.req_valid = 1'b1; vif.req_we = 1'b0; vif.req_addr = 32'h10; vif.req_be = 4'h0;
        @(negedge clk);
        vif.req_valid = 1'b0;
        k = 0;
        while (!vif.rsp_valid && k < 50) begin @(negedge clk); k++; end
        hd = vif.rsp_rdata; he = vif.rsp_err;
        checks++;
        if (vif.rsp_valid !== 1'b1 || hd !== 32'hDEADBEEF || he !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_first_rsp: got valid=%b rdata=%h err=%b, expected 1 deadbeef 0", vif.rsp_valid, hd, he);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (vif.rsp_valid !== 1'b1 || vif.rsp_rdata !== hd || vif.rsp_err !== he || vif.req_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold cycle %0d: got valid=%b rdata=%h err=%b ready=%b, expected 1 %h %b 0",
                         c, vif.rsp_valid, vif.rsp_rdata, vif.rsp_err, vif.req_ready, hd, he);
            end
        end
        vif.rsp_ready = 1'b1;
        @(negedge clk);
        vif.rsp_ready = 1'b0;
        checks++;
        if (vif.req_ready !== 1'b1 || vif.rsp_valid !== 1'b0 || vif.rsp_rdata !== 32'h0 || vif.rsp_err !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_release: got ready=%b valid=%b rdata=%h err=%b, expected 1 0 0 0",
                               vif.req_ready, vif.rsp_valid, vif.rsp_rdata, vif.rsp_err);
        end
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] rd, expRd; logic er, pv, pr, expErr, known, sawValid; int lat;
        select_dut(1);
        drive_txn(1'b1, 32'h30, 32'h11111111, 4'hF, 0, rd, er, lat, pv, pr);
        model_access(curSel, 1'b1, 32'h30, 32'h11111111, 4'hF, expRd, expErr, known);
        checks++;
        if (lat !== 5) begin errors++; $display("[TB] FAIL wait4_latency: got %0d, expected 5", lat); end
        @(negedge clk);
        vif.req_valid = 1'b1; vif.req_we = 1'b1; vif.req_addr = 32'h30;
        vif.req_wdata = 32'h12345678; vif.req_be = 4'hF;
        @(negedge clk);
        vif.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (vif.req_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_store_busy: got ready=%b, expected 0", vif.req_ready); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (vif.req_ready !== 1'b1 || vif.rsp_valid !== 1'b0 || vif.rsp_rdata !== 32'h0 || vif.rsp_err !== 1'b0) begin
            errors++; $display("[TB] FAIL async_reset: got ready=%b valid=%b rdata=%h err=%b, expected 1 0 0 0",
                               vif.req_ready, vif.rsp_valid, vif.rsp_rdata, vif.rsp_err);
        end
        @(negedge clk);
        rst = 1'b1;
        sawValid = 1'b0;
        repeat (8) begin @(negedge clk); if (vif.rsp_valid) sawValid = 1'b1; end
        checks++;
        if (sawValid !== 1'b0) begin errors++; $display("[TB] FAIL discarded_rsp: got rsp_valid=1, expected 0"); end
        drive_txn(1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er, lat, pv, pr);
        checks++;
        if (er !== 1'b0 || rd !== 32'h11111111) begin
            errors++; $display("[TB] FAIL store_not_committed: got err=%b rdata=%h, expected 0 11111111", er, rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, expRd, data [4]; logic er, pv, pr, expErr, known; int lat;
        int acceptT [4]; int rspT [4]; logic [31:0] rspData [4]; logic rspErr [4];
        int issued, got;
        select_dut(2);
        for (int i = 0; i < 4; i++) begin
            data[i] = $urandom;
            drive_txn(1'b1, 32'h40 + 32'(4 * i), data[i], 4'hF, 0, rd, er, lat, pv, pr);
            model_access(curSel, 1'b1, 32'h40 + 32'(4 * i), data[i], 4'hF, expRd, expErr, known);
        end
        issued = 0; got = 0;
        vif.rsp_ready = 1'b1;
        for (int t = 0; t < 40 && got < 4; t++) begin
            @(negedge clk);
            if (vif.rsp_valid) begin
                rspT[got] = t; rspData[got] = vif.rsp_rdata; rspErr[got] = vif.rsp_err; got++;
            end
            if (vif.req_ready && issued < 4) begin
                vif.req_valid = 1'b1; vif.req_we = 1'b0; vif.req_addr = 32'h40 + 32'(4 * issued);
                vif.req_be = 4'($urandom);
                acceptT[issued] = t; issued++;
            end else begin
                vif.req_valid = 1'b0;
            end
        end
        vif.req_valid = 1'b0;
        @(negedge clk);
        vif.rsp_ready = 1'b0;
        checks++;
        if (got !== 4) begin errors++; $display("[TB] FAIL stream_count: got %0d responses, expected 4", got); end
        for (int i = 0; i < got; i++) begin
            model_access(curSel, 1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'h0, expRd, expErr, known);
            checks++;
            if (rspData[i] !== expRd || rspErr[i] !== 1'b0) begin
                errors++; $display("[TB] FAIL stream_data %0d: got rdata=%h err=%b, expected %h 0", i, rspData[i], rspErr[i], expRd);
            end
            // Request is set up the negedge before its accept edge, so the
            // response is visible two negedges later when WAIT_CYCLES is 0.
            checks++;
            if (rspT[i] - acceptT[i] !== 2) begin
                errors++; $display("[TB] FAIL stream_latency %0d: got %0d, expected 2", i, rspT[i] - acceptT[i]);
            end
            if (i > 0) begin
                checks++;
                if (acceptT[i] - acceptT[i-1] !== 3) begin
                    errors++; $display("[TB] FAIL stream_period %0d: got %0d, expected 3", i, acceptT[i] - acceptT[i-1]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, expRd, addr, wdata; logic er, pv, pr, expErr, known, we; logic [3:0] be;
        int lat, kind;
        for (int s = 0; s < 3; s++) begin
            select_dut(s);
            for (int i = 0; i < 8; i++) begin
                wdata = $urandom;
                drive_txn(1'b1, 32'h200 + 32'(4 * i), wdata, 4'hF, 0, rd, er, lat, pv, pr);
                model_access(curSel, 1'b1, 32'h200 + 32'(4 * i), wdata, 4'hF, expRd, expErr, known);
            end
            for (int n = 0; n < 30; n++) begin
                kind  = int'($urandom_range(0, 9));
                addr  = 32'h200 + 32'(4 * $urandom_range(0, 7));
                if (kind == 0) addr = addr + 32'($urandom_range(1, 3));
                if (kind == 1) addr = 32'h1000 | $urandom;
                we    = 1'($urandom);
                wdata = $urandom;
                be    = 4'($urandom);
                drive_txn(we, addr, wdata, be, int'($urandom_range(0, 2)), rd, er, lat, pv, pr);
                model_access(curSel, we, addr, wdata, be, expRd, expErr, known);
                checks++;
                if (er !== expErr || (known && rd !== expRd)) begin
                    errors++; $display("[TB] FAIL random dut%0d txn %0d we=%b addr=%h: got err=%b rdata=%h, expected %b %h",
                                       s, n, we, addr, er, rd, expErr, expRd);
                end
                checks++;
                if (lat !== curW + 1 || pv !== 1'b0 || pr !== 1'b1) begin
                    errors++; $display("[TB] FAIL random_timing dut%0d txn %0d: got lat=%0d valid=%b ready=%b, expected %0d 0 1",
                                       s, n, lat, pv, pr, curW + 1);
                end
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        checks = 0;
        errors = 0;
        idle_all();
        test_reset();
        test_store_load();
        test_byte_enables();
        test_errors();
        test_backpressure();
        test_reset_mid_store();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the core's data port: accepts one load/store request at a time over a valid/ready handshake. It services the request from a byte-enabled word array after a programmable number of wait states and returns a response over a second valid/ready handshake. It sits between the pipelined core's MEM stage and backing storage, and replaces the zero-latency combinational data memory once the core gains stall-on-memory support.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, ≥ 4.
- WAIT_CYCLES, 2: extra cycles between request accept and memory access; legal range 0–15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables for stores; bit i covers bits [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or out-of-range access.

## Operation
- The FSM has three states: IDLE, WAIT, RESP. At most one transaction is outstanding.
- req_ready = (state == IDLE). It is a pure state decode, with no combinational path from req_valid.
- Accept: req_valid && req_ready at an edge.
  - Latch we, addr, wdata, be.
  - Load wait counter with WAIT_CYCLES.
  - Go to WAIT.
- WAIT:
  - If counter ≠ 0, decrement it.
  - If counter == 0, perform the access at this edge and go to RESP.
- Access:
  - Error if addr[1:0] ≠ 0 or addr ≥ 4·DEPTH_WORDS. On error: no array write, rsp_err=1, rsp_rdata=0.
  - Otherwise the word index is addr[2 +: log2(DEPTH_WORDS)].
  - Store: write only the enabled bytes; rsp_rdata=0. be=0 is a legal no-op store.
  - Load: rsp_rdata = full word at the index; be is ignored.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready.
  - On that edge go to IDLE and clear rsp_valid, rsp_rdata, rsp_err.
- Request inputs are ignored outside IDLE. They are sampled only at the accept edge.
- Array contents are not reset and are undefined until written.

## Timing
- Reset (rst low, asynchronous):
  - state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
  - req_ready=1 while in reset and afterwards.
- Latency: accept at edge N → rsp_valid high after edge N+1+WAIT_CYCLES.
  - WAIT_CYCLES=0 gives rsp_valid after N+1.
- Store commit happens at edge N+1+WAIT_CYCLES. A load issued afterwards observes it.
- Back-pressure: rsp_ready low holds RESP indefinitely, with outputs frozen.
- Response handshake at edge M → req_ready high after M. The next accept can occur at M+1.
  - Minimum period per transaction: WAIT_CYCLES+3 cycles.
- rsp_ready already high when RESP is entered: the handshake completes on the first RESP edge.
- Reset mid-transaction (WAIT or RESP):
  - The transaction is discarded. A store still in WAIT is never committed.
  - Outputs return to reset values immediately.
- A wait counter load of 0 and the access edge are the same as the WAIT_CYCLES=0 case. No special path bypasses WAIT.

## Structure
- Shared package mem_if_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - WORD_BYTES=4;
  - BE_W=4;
  - a request struct (we, addr, wdata, be). The core side reuses it for its initiator.
- Sub-module sram_1rw holds the array: synchronous, single port, byte-enabled write, read data registered on the same edge. Parameter: DEPTH_WORDS.
- The FSM, wait counter, error check and output registers live in data_mem_responder.

## Test plan
- WAIT_CYCLES=2: store addr 0x10, wdata 0xDEADBEEF, be=0xF, then load 0x10.
  - Load rsp_rdata=0xDEADBEEF, rsp_err=0.
  - Each rsp_valid rises exactly 3 edges after its accept.
- Byte enables:
  - Store 0xFFFFFFFF be=0xF at 0x20, then store 0x00000000 be=0x5 at 0x20.
  - Load 0x20 returns 0xFF00FF00.
- Errors:
  - Load 0x22 → rsp_err=1, rsp_rdata=0.
  - Store 0x1000 with DEPTH_WORDS=1024 → rsp_err=1, and a later load of 0x0 still returns its previous value.
- Back-pressure:
  - Hold rsp_ready=0 for 5 cycles during a load of 0x10: rsp_valid, rsp_rdata and rsp_err stay constant and req_ready stays 0.
  - Release rsp_ready: req_ready is 1 on the following cycle.
- Reset mid-store:
  - Store 0x12345678 to 0x30 (WAIT_CYCLES=4), pulse rst low during WAIT.
  - Outputs go to reset values at once, and a later load of 0x30 returns the pre-store value.
- WAIT_CYCLES=0 streaming with rsp_ready tied high: 4 back-to-back loads complete one every 3 cycles, returning correct data in order.
